dpb_bank_arbiter: RTL and testbench

DPB_BANK_ARBITER -- requirements
Module: dpb_bank_arbiter

---
 rtl/dpb_pkg.sv | 32 +++
 rtl/dpb_meta_fifo.sv | 70 +++++++
 rtl/dpb_bank_arbiter.sv | 141 ++++++++++++++
 tb/tb_dpb_bank_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpb_pkg.sv
// Shared constants, writer-state type and payload-size helpers for the DPB bank arbiter.
package dpb_pkg;

    localparam int NUM_BANK  = 16;
    localparam int WORD_W    = 7;
    localparam int BYTES_MAX = 2048;
    localparam int BANK_W    = $clog2(NUM_BANK);
    localparam int ADDR_W    = BANK_W + WORD_W;
    localparam int CNT_W     = BANK_W + 1;
    localparam int BYTES_W   = 12;
    localparam int FRAME_W   = 15;
    localparam int META_W    = BYTES_W + 1;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_OWN  = 1'b1
    } wr_state_t;

    function automatic logic bytes_bad(input logic [BYTES_W-1:0] b, input logic [BYTES_W-1:0] max_v);
        return (b == {BYTES_W{1'b0}}) || (b > max_v);
    endfunction

    // Out-of-range byte counts are stored as a full bank so the reader never sees zero.
    function automatic logic [BYTES_W-1:0] clamp_bytes(input logic [BYTES_W-1:0] b, input logic [BYTES_W-1:0] max_v);
        if (bytes_bad(b, max_v)) begin
            return max_v;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/dpb_meta_fifo.sv
// Show-ahead metadata FIFO, one entry per committed bank; head is visible without a read strobe.
module dpb_meta_fifo
    import dpb_pkg::*;
#(
    parameter int DEPTH  = dpb_pkg::NUM_BANK,
    parameter int DATA_W = dpb_pkg::META_W
)(
    input  logic                       i_cam_pclk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head_data,
    output logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       not_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_V = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_idx_r;
    logic [AW-1:0]     rd_idx_r;
    logic [AW:0]       count_r;
    logic              not_empty_r;
    logic              push_ok_s;
    logic              pop_ok_s;
    logic [AW:0]       count_nxt_s;

    assign push_ok_s   = push && (count_r != FULL_V);
    assign pop_ok_s    = pop && not_empty_r;
    assign count_nxt_s = count_r + (AW+1)'(push_ok_s) - (AW+1)'(pop_ok_s);

    // Entry storage, cleared on reset so the head reads zero when nothing is queued.
    always_ff @(posedge i_cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_idx_r] <= push_data;
        end
    end

    // Ring pointers, occupancy and the registered non-empty flag.
    always_ff @(posedge i_cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_r    <= {AW{1'b0}};
            rd_idx_r    <= {AW{1'b0}};
            count_r     <= {(AW+1){1'b0}};
            not_empty_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_idx_r <= wr_idx_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_idx_r <= rd_idx_r + AW'(1);
            end
            count_r     <= count_nxt_s;
            not_empty_r <= (count_nxt_s != {(AW+1){1'b0}});
        end
    end

    assign head_data = mem_r[rd_idx_r];
    assign rd_idx    = rd_idx_r;
    assign count     = count_r;
    assign not_empty = not_empty_r;

endmodule

// File: rtl/dpb_bank_arbiter.sv
// Ring-ordered bank allocator between the JPEG writer and the DPB reader, with
// per-bank metadata queue, free/fill/frame counters and a sticky protocol-error flag.
module dpb_bank_arbiter
    import dpb_pkg::*;
#(
    parameter int NUM_BANK  = dpb_pkg::NUM_BANK,
    parameter int WORD_W    = dpb_pkg::WORD_W,
    parameter int BYTES_MAX = dpb_pkg::BYTES_MAX
)(
    input  logic                                 i_cam_pclk,
    input  logic                                 rst_n,
    input  logic                                 i_wr_alloc_req,
    output logic                                 o_wr_alloc_gnt,
    output logic [$clog2(NUM_BANK)-1:0]          o_wr_bank,
    output logic [$clog2(NUM_BANK)+WORD_W-1:0]   o_wr_base_addr,
    input  logic                                 i_wr_commit,
    input  logic [BYTES_W-1:0]                   i_wr_commit_bytes,
    input  logic                                 i_wr_commit_last,
    output logic                                 o_rd_valid,
    output logic [$clog2(NUM_BANK)-1:0]          o_rd_bank,
    output logic [$clog2(NUM_BANK)+WORD_W-1:0]   o_rd_base_addr,
    output logic [BYTES_W-1:0]                   o_rd_bytes,
    output logic                                 o_rd_last,
    input  logic                                 i_rd_release,
    output logic [$clog2(NUM_BANK):0]            o_free_cnt,
    output logic [$clog2(NUM_BANK):0]            o_fill_cnt,
    output logic [FRAME_W-1:0]                   o_frame_cnt,
    output logic                                 o_error
);

    localparam int BK_W = $clog2(NUM_BANK);
    localparam logic [BYTES_W-1:0] MAX_V  = BYTES_W'(BYTES_MAX);
    localparam logic [BK_W:0]      FULL_V = (BK_W+1)'(NUM_BANK);

    wr_state_t         state_r;
    wr_state_t         state_nxt_s;
    logic              gnt_s;
    logic              commit_ok_s;
    logic              release_ok_s;
    logic              err_evt_s;
    logic              rd_valid_s;
    logic [META_W-1:0] head_s;
    logic [META_W-1:0] push_data_s;
    logic [BK_W-1:0]   rd_idx_s;
    logic [BK_W:0]     fill_s;

    logic              gnt_r;
    logic [BK_W-1:0]   wr_ptr_r;
    logic [BK_W:0]     free_r;
    logic [FRAME_W-1:0] frame_r;
    logic              err_r;

    // Writer state register.
    always_ff @(posedge i_cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= W_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Writer next-state: grant takes ownership, commit hands it back.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            W_IDLE:  state_nxt_s = gnt_s ? W_OWN : W_IDLE;
            W_OWN:   state_nxt_s = i_wr_commit ? W_IDLE : W_OWN;
            default: state_nxt_s = W_IDLE;
        endcase
    end

    // Writer decode: a grant is only possible from idle, so it never coincides with a commit.
    always_comb begin
        gnt_s       = 1'b0;
        commit_ok_s = 1'b0;
        case (state_r)
            W_IDLE:  gnt_s = i_wr_alloc_req && (free_r != {(BK_W+1){1'b0}});
            W_OWN:   commit_ok_s = i_wr_commit;
            default: begin
                gnt_s       = 1'b0;
                commit_ok_s = 1'b0;
            end
        endcase
    end

    assign release_ok_s = i_rd_release && rd_valid_s;
    assign err_evt_s    = (i_wr_commit && !commit_ok_s)
                        || (i_rd_release && !rd_valid_s)
                        || (commit_ok_s && bytes_bad(i_wr_commit_bytes, MAX_V));
    assign push_data_s  = {i_wr_commit_last, clamp_bytes(i_wr_commit_bytes, MAX_V)};

    // Grant pulse, write pointer, free/frame counters and sticky error.
    always_ff @(posedge i_cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_r    <= 1'b0;
            wr_ptr_r <= {BK_W{1'b0}};
            free_r   <= FULL_V;
            frame_r  <= {FRAME_W{1'b0}};
            err_r    <= 1'b0;
        end else begin
            gnt_r  <= gnt_s;
            free_r <= free_r - (BK_W+1)'(gnt_s) + (BK_W+1)'(release_ok_s);
            err_r  <= err_r || err_evt_s;
            if (commit_ok_s) begin
                wr_ptr_r <= wr_ptr_r + BK_W'(1);
            end
            if (commit_ok_s && i_wr_commit_last) begin
                frame_r <= frame_r + FRAME_W'(1);
            end
        end
    end

    dpb_meta_fifo #(
        .DEPTH  (NUM_BANK),
        .DATA_W (META_W)
    ) u_meta_fifo (
        .i_cam_pclk (i_cam_pclk),
        .rst_n      (rst_n),
        .push       (commit_ok_s),
        .push_data  (push_data_s),
        .pop        (release_ok_s),
        .head_data  (head_s),
        .rd_idx     (rd_idx_s),
        .count      (fill_s),
        .not_empty  (rd_valid_s)
    );

    assign o_wr_alloc_gnt = gnt_r;
    assign o_wr_bank      = wr_ptr_r;
    assign o_wr_base_addr = {wr_ptr_r, {WORD_W{1'b0}}};
    assign o_rd_valid     = rd_valid_s;
    assign o_rd_bank      = rd_idx_s;
    assign o_rd_base_addr = {rd_idx_s, {WORD_W{1'b0}}};
    assign o_rd_bytes     = head_s[BYTES_W-1:0];
    assign o_rd_last      = head_s[META_W-1];
    assign o_free_cnt     = free_r;
    assign o_fill_cnt     = fill_s;
    assign o_frame_cnt    = frame_r;
    assign o_error        = err_r;

endmodule

// File: tb/tb_dpb_bank_arbiter.sv
// Directed and model-checked stimulus for dpb_bank_arbiter.
module tb_dpb_bank_arbiter;

    logic        i_cam_pclk;
    logic        rst_n;
    logic        i_wr_alloc_req;
    logic        o_wr_alloc_gnt;
    logic [3:0]  o_wr_bank;
    logic [10:0] o_wr_base_addr;
    logic        i_wr_commit;
    logic [11:0] i_wr_commit_bytes;
    logic        i_wr_commit_last;
    logic        o_rd_valid;
    logic [3:0]  o_rd_bank;
    logic [10:0] o_rd_base_addr;
    logic [11:0] o_rd_bytes;
    logic        o_rd_last;
    logic        i_rd_release;
    logic [4:0]  o_free_cnt;
    logic [4:0]  o_fill_cnt;
    logic [14:0] o_frame_cnt;
    logic        o_error;

    int checks = 0;
    int errors = 0;

    localparam logic [70:0] RST_V = {1'b0, 4'd0, 11'd0, 1'b0, 4'd0, 11'd0, 12'd0, 1'b0, 5'd16, 5'd0, 15'd0, 1'b0};
    logic [70:0] outs;
    assign outs = {o_wr_alloc_gnt, o_wr_bank, o_wr_base_addr, o_rd_valid, o_rd_bank, o_rd_base_addr,
                   o_rd_bytes, o_rd_last, o_free_cnt, o_fill_cnt, o_frame_cnt, o_error};

    dpb_bank_arbiter dut (
        .i_cam_pclk        (i_cam_pclk),
        .rst_n             (rst_n),
        .i_wr_alloc_req    (i_wr_alloc_req),
        .o_wr_alloc_gnt    (o_wr_alloc_gnt),
        .o_wr_bank         (o_wr_bank),
        .o_wr_base_addr    (o_wr_base_addr),
        .i_wr_commit       (i_wr_commit),
        .i_wr_commit_bytes (i_wr_commit_bytes),
        .i_wr_commit_last  (i_wr_commit_last),
        .o_rd_valid        (o_rd_valid),
        .o_rd_bank         (o_rd_bank),
        .o_rd_base_addr    (o_rd_base_addr),
        .o_rd_bytes        (o_rd_bytes),
        .o_rd_last         (o_rd_last),
        .i_rd_release      (i_rd_release),
        .o_free_cnt        (o_free_cnt),
        .o_fill_cnt        (o_fill_cnt),
        .o_frame_cnt       (o_frame_cnt),
        .o_error           (o_error)
    );

    initial i_cam_pclk = 1'b0;
    always #5 i_cam_pclk = ~i_cam_pclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge i_cam_pclk);
        #1;
    endtask

    task automatic clear_inputs;
        i_wr_alloc_req    = 1'b0;
        i_wr_commit       = 1'b0;
        i_wr_commit_bytes = 12'd0;
        i_wr_commit_last  = 1'b0;
        i_rd_release      = 1'b0;
    endtask

    task automatic apply_reset;
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic grant_bank;
        i_wr_alloc_req = 1'b1;
        tick();
        i_wr_alloc_req = 1'b0;
    endtask

    task automatic commit_bank(input logic [11:0] bytes, input logic last);
        i_wr_commit       = 1'b1;
        i_wr_commit_bytes = bytes;
        i_wr_commit_last  = last;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset;
        clear_inputs();
        rst_n = 1'b0;
        tick();
        checks++;
        if (outs !== RST_V) begin errors++; $display("FAIL reset_outputs: got %h expected %h", outs, RST_V); end
        rst_n = 1'b1;
        tick();
        checks++;
        if (outs !== RST_V) begin errors++; $display("FAIL reset_release_outputs: got %h expected %h", outs, RST_V); end
    endtask

    task automatic test_first_grant;
        grant_bank();
        checks++;
        if (o_wr_alloc_gnt !== 1'b1) begin errors++; $display("FAIL first_gnt: got %b expected 1", o_wr_alloc_gnt); end
        checks++;
        if ({o_wr_bank, o_wr_base_addr} !== 15'd0) begin errors++; $display("FAIL first_bank: got %0d/%0d expected 0/0", o_wr_bank, o_wr_base_addr); end
        checks++;
        if (o_free_cnt !== 5'd15) begin errors++; $display("FAIL first_free: got %0d expected 15", o_free_cnt); end
        tick();
        checks++;
        if (o_wr_alloc_gnt !== 1'b0) begin errors++; $display("FAIL gnt_one_cycle: got %b expected 0", o_wr_alloc_gnt); end
    endtask

    task automatic test_fill_and_wrap;
        for (int i = 0; i < 16; i++) begin
            if (i != 0) grant_bank();
            commit_bank(12'd2048, (i == 15));
        end
        checks++;
        if ({o_free_cnt, o_fill_cnt, o_frame_cnt} !== {5'd0, 5'd16, 15'd1}) begin
            errors++; $display("FAIL full_counts: got free=%0d fill=%0d frame=%0d expected 0/16/1", o_free_cnt, o_fill_cnt, o_frame_cnt);
        end
        checks++;
        if ({o_rd_valid, o_rd_bank, o_rd_bytes, o_rd_last, o_error} !== {1'b1, 4'd0, 12'd2048, 1'b0, 1'b0}) begin
            errors++; $display("FAIL full_head: got v=%b bank=%0d bytes=%0d last=%b err=%b expected 1/0/2048/0/0",
                               o_rd_valid, o_rd_bank, o_rd_bytes, o_rd_last, o_error);
        end
        i_wr_alloc_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (o_wr_alloc_gnt !== 1'b0) begin errors++; $display("FAIL stall_gnt%0d: got %b expected 0", i, o_wr_alloc_gnt); end
        end
        i_rd_release = 1'b1;
        tick();
        i_rd_release = 1'b0;
        checks++;
        if ({o_wr_alloc_gnt, o_free_cnt, o_fill_cnt, o_rd_bank} !== {1'b0, 5'd1, 5'd15, 4'd1}) begin
            errors++; $display("FAIL release_full: got gnt=%b free=%0d fill=%0d rd_bank=%0d expected 0/1/15/1",
                               o_wr_alloc_gnt, o_free_cnt, o_fill_cnt, o_rd_bank);
        end
        tick();
        i_wr_alloc_req = 1'b0;
        checks++;
        if ({o_wr_alloc_gnt, o_wr_bank, o_wr_base_addr, o_free_cnt, o_frame_cnt} !== {1'b1, 4'd0, 11'd0, 5'd0, 15'd1}) begin
            errors++; $display("FAIL wrap_grant: got gnt=%b bank=%0d base=%0d free=%0d frame=%0d expected 1/0/0/0/1",
                               o_wr_alloc_gnt, o_wr_bank, o_wr_base_addr, o_free_cnt, o_frame_cnt);
        end
    endtask

    task automatic test_commit_release_same_cycle;
        i_rd_release = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        i_rd_release = 1'b0;
        checks++;
        if ({o_fill_cnt, o_free_cnt, o_rd_bank} !== {5'd3, 5'd12, 4'd13}) begin
            errors++; $display("FAIL pre_concurrent: got fill=%0d free=%0d rd_bank=%0d expected 3/12/13", o_fill_cnt, o_free_cnt, o_rd_bank);
        end
        i_wr_commit       = 1'b1;
        i_wr_commit_bytes = 12'd300;
        i_wr_commit_last  = 1'b1;
        i_rd_release      = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if ({o_fill_cnt, o_free_cnt, o_rd_bank, o_rd_bytes, o_rd_last, o_frame_cnt} !== {5'd3, 5'd13, 4'd14, 12'd2048, 1'b0, 15'd2}) begin
            errors++; $display("FAIL concurrent: got fill=%0d free=%0d rd_bank=%0d bytes=%0d last=%b frame=%0d expected 3/13/14/2048/0/2",
                               o_fill_cnt, o_free_cnt, o_rd_bank, o_rd_bytes, o_rd_last, o_frame_cnt);
        end
        i_rd_release = 1'b1;
        tick();
        i_rd_release = 1'b0;
        checks++;
        if ({o_rd_bank, o_rd_last} !== {4'd15, 1'b1}) begin
            errors++; $display("FAIL head_bank15: got bank=%0d last=%b expected 15/1", o_rd_bank, o_rd_last);
        end
        i_rd_release = 1'b1;
        tick();
        i_rd_release = 1'b0;
        checks++;
        if ({o_rd_bank, o_rd_base_addr, o_rd_bytes, o_rd_last, o_fill_cnt, o_free_cnt} !== {4'd0, 11'd0, 12'd300, 1'b1, 5'd1, 5'd15}) begin
            errors++; $display("FAIL head_wrapped: got bank=%0d base=%0d bytes=%0d last=%b fill=%0d free=%0d expected 0/0/300/1/1/15",
                               o_rd_bank, o_rd_base_addr, o_rd_bytes, o_rd_last, o_fill_cnt, o_free_cnt);
        end
    endtask

    task automatic test_errors;
        apply_reset();
        commit_bank(12'd100, 1'b0);
        checks++;
        if ({o_error, o_free_cnt, o_fill_cnt, o_frame_cnt} !== {1'b1, 5'd16, 5'd0, 15'd0}) begin
            errors++; $display("FAIL err_idle_commit: got err=%b free=%0d fill=%0d frame=%0d expected 1/16/0/0", o_error, o_free_cnt, o_fill_cnt, o_frame_cnt);
        end
        tick();
        tick();
        checks++;
        if (o_error !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", o_error); end

        apply_reset();
        i_rd_release = 1'b1;
        tick();
        i_rd_release = 1'b0;
        checks++;
        if ({o_error, o_free_cnt, o_fill_cnt, o_rd_valid, o_rd_bank} !== {1'b1, 5'd16, 5'd0, 1'b0, 4'd0}) begin
            errors++; $display("FAIL err_empty_release: got err=%b free=%0d fill=%0d v=%b bank=%0d expected 1/16/0/0/0",
                               o_error, o_free_cnt, o_fill_cnt, o_rd_valid, o_rd_bank);
        end

        apply_reset();
        grant_bank();
        checks++;
        if (o_error !== 1'b0) begin errors++; $display("FAIL err_clean_grant: got %b expected 0", o_error); end
        commit_bank(12'd0, 1'b0);
        checks++;
        if ({o_error, o_fill_cnt, o_free_cnt, o_rd_valid, o_rd_bytes} !== {1'b1, 5'd1, 5'd15, 1'b1, 12'd2048}) begin
            errors++; $display("FAIL err_zero_bytes: got err=%b fill=%0d free=%0d v=%b bytes=%0d expected 1/1/15/1/2048",
                               o_error, o_fill_cnt, o_free_cnt, o_rd_valid, o_rd_bytes);
        end

        apply_reset();
        grant_bank();
        commit_bank(12'd2049, 1'b1);
        checks++;
        if ({o_error, o_fill_cnt, o_rd_bytes, o_rd_last, o_frame_cnt} !== {1'b1, 5'd1, 12'd2048, 1'b1, 15'd1}) begin
            errors++; $display("FAIL err_over_bytes: got err=%b fill=%0d bytes=%0d last=%b frame=%0d expected 1/1/2048/1/1",
                               o_error, o_fill_cnt, o_rd_bytes, o_rd_last, o_frame_cnt);
        end
    endtask

    task automatic test_reset_mid_own;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            grant_bank();
            commit_bank((i == 2) ? 12'd0 : 12'd100, 1'b1);
        end
        grant_bank();
        checks++;
        if ({o_fill_cnt, o_free_cnt, o_error} !== {5'd5, 5'd10, 1'b1}) begin
            errors++; $display("FAIL pre_mid_reset: got fill=%0d free=%0d err=%b expected 5/10/1", o_fill_cnt, o_free_cnt, o_error);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== RST_V) begin errors++; $display("FAIL mid_reset_async: got %h expected %h", outs, RST_V); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (outs !== RST_V) begin errors++; $display("FAIL mid_reset_after: got %h expected %h", outs, RST_V); end
    endtask

    task automatic test_random;
        logic        own_m   = 1'b0;
        logic [4:0]  free_m  = 5'd16;
        logic [4:0]  fill_m  = 5'd0;
        logic [3:0]  wr_m    = 4'd0;
        logic [3:0]  rd_m    = 4'd0;
        logic [14:0] frame_m = 15'd0;
        logic [12:0] q[$];
        logic        gnt_e;
        logic        c_ok;
        logic        r_ok;
        logic [11:0] b;
        logic        l;
        apply_reset();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            b = 12'($urandom_range(1, 2048));
            l = ($urandom_range(0, 7) == 0);
            i_wr_alloc_req    = ($urandom_range(0, 1) == 1);
            i_wr_commit       = own_m && ($urandom_range(0, 1) == 1);
            i_wr_commit_bytes = b;
            i_wr_commit_last  = l;
            i_rd_release      = (fill_m != 5'd0) && ($urandom_range(0, 2) == 0);
            if (i_rd_release) begin
                checks++;
                if ({o_rd_last, o_rd_bytes, o_rd_bank} !== {q[0], rd_m}) begin
                    errors++; $display("FAIL rnd_read_order @%0d: got %h/%0d expected %h/%0d", cyc, {o_rd_last, o_rd_bytes}, o_rd_bank, q[0], rd_m);
                end
            end
            gnt_e = !own_m && i_wr_alloc_req && (free_m != 5'd0);
            c_ok  = i_wr_commit;
            r_ok  = i_rd_release;
            tick();
            if (c_ok) begin
                q.push_back({l, b});
                wr_m = wr_m + 4'd1;
                if (l) frame_m = frame_m + 15'd1;
            end
            if (r_ok) begin
                void'(q.pop_front());
                rd_m = rd_m + 4'd1;
            end
            free_m = free_m - 5'(gnt_e) + 5'(r_ok);
            fill_m = fill_m + 5'(c_ok) - 5'(r_ok);
            own_m  = own_m ? !c_ok : gnt_e;
            checks++;
            if ({o_wr_alloc_gnt, o_free_cnt, o_fill_cnt, o_rd_valid, o_frame_cnt} !== {gnt_e, free_m, fill_m, (fill_m != 5'd0), frame_m}) begin
                errors++; $display("FAIL rnd_state @%0d: got gnt=%b free=%0d fill=%0d v=%b frame=%0d expected %b/%0d/%0d/%b/%0d",
                                   cyc, o_wr_alloc_gnt, o_free_cnt, o_fill_cnt, o_rd_valid, o_frame_cnt,
                                   gnt_e, free_m, fill_m, (fill_m != 5'd0), frame_m);
            end
            checks++;
            if (6'(o_free_cnt) + 6'(o_fill_cnt) + 6'(own_m) !== 6'd16) begin
                errors++; $display("FAIL rnd_invariant @%0d: got free=%0d fill=%0d own=%b expected sum 16", cyc, o_free_cnt, o_fill_cnt, own_m);
            end
            if (gnt_e) begin
                checks++;
                if (o_wr_bank !== wr_m) begin errors++; $display("FAIL rnd_wr_bank @%0d: got %0d expected %0d", cyc, o_wr_bank, wr_m); end
            end
        end
        clear_inputs();
        tick();
        checks++;
        if (o_error !== 1'b0) begin errors++; $display("FAIL rnd_no_error: got %b expected 0", o_error); end
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_first_grant();
        test_fill_and_wrap();
        test_commit_release_same_cycle();
        test_errors();
        test_reset_mid_own();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
